// File: rtl/alu_sched.sv
// Two-requester scheduler for one shared external 8-bit ALU. It grants requesters round-robin,
// waits out the ALU latency, and returns the result to the granted requester.
// Optional feature: ALU_SCHED_DIV0_CHECK_EN answers a divide by zero locally instead of
// issuing it to the ALU.
module alu_sched #(
  parameter int OP_LAT  = 1,
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_sel,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, EXEC, RESP, DIV0} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         alu_a_q, alu_a_d;
  logic [7:0]         alu_b_q, alu_b_d;
  logic [3:0]         alu_sel_q, alu_sel_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               rsp_err_q, rsp_err_d;

  logic               gnt_idx;
  logic               accept;
  logic               is_div0;
  logic [7:0]         s_a, s_b;
  logic [3:0]         s_sel;

  // A lone requester wins regardless of the pointer; the pointer only breaks ties.
  always_comb begin
    gnt_idx = ptr_q;
    if (req_valid == 2'b01)      gnt_idx = 1'b0;
    else if (req_valid == 2'b10) gnt_idx = 1'b1;
  end

  assign accept    = !rst && (state_q == IDLE) && (|req_valid);
  assign req_ready = accept ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  assign s_a   = gnt_idx ? req_a[15:8]  : req_a[7:0];
  assign s_b   = gnt_idx ? req_b[15:8]  : req_b[7:0];
  assign s_sel = gnt_idx ? req_sel[7:4] : req_sel[3:0];

`ifdef ALU_SCHED_DIV0_CHECK_EN
  assign is_div0 = (s_sel == 4'd3) && (s_b == 8'd0);
`else
  assign is_div0 = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt_idx;
          if (is_div0) begin
            state_d = DIV0;
          end else begin
            alu_a_d   = s_a;
            alu_b_d   = s_b;
            alu_sel_d = s_sel;
            cnt_d     = (s_sel == 4'd2) ? CNT_W'(MUL_LAT) : CNT_W'(OP_LAT);
            state_d   = EXEC;
          end
        end
      end
      // Counter runs LAT..0, so EXEC lasts LAT+1 cycles before the ALU output is sampled.
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_carry;
          rsp_err_d   = 1'b0;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV0: begin
        rsp_data_d  = 8'h00;
        rsp_carry_d = 1'b0;
        rsp_err_d   = 1'b1;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          ptr_d       = ~owner_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_sel_q   <= 4'h0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= 8'h00;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: a small behavioural ALU sits on the alu_* ports and each
// scenario task checks its own hand-computed results.
module tb_alu_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [7:0]  req_sel = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [7:0]  rsp_data;
  logic        rsp_carry;
  logic        rsp_err;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic [15:0] prod;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  alu_sched #(.OP_LAT(1), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add/sub/mul/div, anything else is AND; divide by zero yields 8'hFF.
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    prod      = alu_a * alu_b;
    case (alu_sel)
      4'd0: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = prod[7:0];
      4'd3: alu_out = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
      default: alu_out = alu_a & alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests an op and returns edges from accept to rsp_valid, or -1 if a bound expires.
  task automatic issue(input int r, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] s, output int lat);
    int n;
    req_a[8*r +: 8]   = a;
    req_b[8*r +: 8]   = b;
    req_sel[4*r +: 4] = s;
    req_valid[r]      = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 20) begin tick(); n++; end
    lat = -1;
    if (req_ready[r]) begin
      tick();
      req_valid[r] = 1'b0;
      n = 0;
      while (!rsp_valid[r] && n < 20) begin tick(); n++; end
      if (rsp_valid[r]) lat = n;
    end
  endtask

  task automatic finish_rsp(input int r);
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    chk_cnt++; if (req_ready !== 2'b00) $display("FAIL rst_req_ready got %b exp 00", req_ready); else pass_cnt++;
    req_valid = 2'b00;
    tick();
    chk_cnt++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid got %b exp 00", rsp_valid); else pass_cnt++;
    chk_cnt++; if ({rsp_data, rsp_carry, rsp_err} !== 10'h0) $display("FAIL rst_rsp got %h/%b/%b exp 0", rsp_data, rsp_carry, rsp_err); else pass_cnt++;
    chk_cnt++; if ({alu_a, alu_b, alu_sel} !== 20'h0) $display("FAIL rst_alu got %h %h %h exp 0", alu_a, alu_b, alu_sel); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int lat;
    issue(0, 8'd100, 8'd55, 4'd0, lat);
    chk_cnt++; if (lat != 2) $display("FAIL add_lat got %0d exp 2", lat); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 2'b01) $display("FAIL add_valid got %b exp 01", rsp_valid); else pass_cnt++;
    chk_cnt++; if ({rsp_data, rsp_carry, rsp_err} !== {8'd155, 1'b0, 1'b0}) $display("FAIL add_rsp got %0d/%b/%b exp 155/0/0", rsp_data, rsp_carry, rsp_err); else pass_cnt++;
    chk_cnt++; if ({alu_a, alu_b, alu_sel} !== {8'd100, 8'd55, 4'd0}) $display("FAIL add_alu got %0d %0d %0d exp 100 55 0", alu_a, alu_b, alu_sel); else pass_cnt++;
    finish_rsp(0);
  endtask

  task automatic test_req1();
    int lat;
    issue(1, 8'd200, 8'd100, 4'd0, lat);
    chk_cnt++; if (lat != 2) $display("FAIL r1add_lat got %0d exp 2", lat); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 2'b10) $display("FAIL r1add_valid got %b exp 10", rsp_valid); else pass_cnt++;
    chk_cnt++; if ({rsp_data, rsp_carry} !== {8'd44, 1'b1}) $display("FAIL r1add_rsp got %0d/%b exp 44/1", rsp_data, rsp_carry); else pass_cnt++;
    finish_rsp(1);
    issue(1, 8'd12, 8'd10, 4'd2, lat);
    chk_cnt++; if (lat != 3) $display("FAIL mul_lat got %0d exp 3", lat); else pass_cnt++;
    chk_cnt++; if (rsp_data !== 8'd120) $display("FAIL mul_data got %0d exp 120", rsp_data); else pass_cnt++;
    finish_rsp(1);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    logic       multi;
    int         n;
    multi     = 1'b0;
    req_a     = {8'd20, 8'd10};
    req_b     = {8'd3, 8'd5};
    req_sel   = 8'h00;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin tick(); n++; end
      chk_cnt++; if (req_ready !== exp_rdy) $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp_rdy); else pass_cnt++;
      tick();
      n = 0;
      while (rsp_valid == 2'b00 && n < 20) begin tick(); n++; end
      if ($countones(rsp_valid) > 1) multi = 1'b1;
      chk_cnt++; if (rsp_valid !== exp_rdy) $display("FAIL rr_rsp%0d got %b exp %b", k, rsp_valid, exp_rdy); else pass_cnt++;
      chk_cnt++; if (rsp_data !== ((k % 2 == 0) ? 8'd15 : 8'd23)) $display("FAIL rr_data%0d got %0d", k, rsp_data); else pass_cnt++;
      rsp_ready = 2'b11;
      tick();
      if ($countones(rsp_valid) > 1) multi = 1'b1;
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    chk_cnt++; if (multi !== 1'b0) $display("FAIL rr_onehot got multi=%b exp 0", multi); else pass_cnt++;
    tick();
  endtask

  task automatic test_stall();
    int   lat;
    logic bad;
    issue(0, 8'd50, 8'd20, 4'd1, lat);
    chk_cnt++; if (lat != 2 || rsp_data !== 8'd30) $display("FAIL sub_rsp got lat %0d data %0d exp 2 30", lat, rsp_data); else pass_cnt++;
    bad       = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    repeat (5) begin
      #1;
      if (rsp_valid !== 2'b01 || rsp_data !== 8'd30 || req_ready !== 2'b00) bad = 1'b1;
      tick();
    end
    chk_cnt++; if (bad !== 1'b0) $display("FAIL stall_hold got unstable=%b exp 0", bad); else pass_cnt++;
    rsp_ready = 2'b01;
    #1;
    chk_cnt++; if (req_ready !== 2'b00) $display("FAIL stall_hs_ready got %b exp 00", req_ready); else pass_cnt++;
    tick();
    rsp_ready = 2'b00;
    #1;
    chk_cnt++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) $display("FAIL post_hs got valid %b ready %b exp 00 10", rsp_valid, req_ready); else pass_cnt++;
    req_valid = 2'b01;
    #1;
    chk_cnt++; if (req_ready !== 2'b01) $display("FAIL single_grant got %b exp 01", req_ready); else pass_cnt++;
    req_valid = 2'b00;
    tick();
    #1;
    chk_cnt++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) $display("FAIL cancel got valid %b ready %b exp 00 00", rsp_valid, req_ready); else pass_cnt++;
    req_valid = 2'b11;
    #1;
    chk_cnt++; if (req_ready !== 2'b10) $display("FAIL cancel_ptr got %b exp 10", req_ready); else pass_cnt++;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_midop();
    logic seen;
    req_a[15:8]  = 8'd9;
    req_b[15:8]  = 8'd3;
    req_sel[7:4] = 4'd3;
    req_valid    = 2'b10;
    #1;
    chk_cnt++; if (req_ready !== 2'b10) $display("FAIL mid_grant got %b exp 10", req_ready); else pass_cnt++;
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++; if ({rsp_valid, rsp_data, rsp_carry, rsp_err} !== 12'h0) $display("FAIL mid_rsp got %b %h %b %b exp 0", rsp_valid, rsp_data, rsp_carry, rsp_err); else pass_cnt++;
    chk_cnt++; if ({alu_a, alu_b, alu_sel} !== 20'h0) $display("FAIL mid_alu got %h %h %h exp 0", alu_a, alu_b, alu_sel); else pass_cnt++;
    seen = 1'b0;
    repeat (4) begin
      if (rsp_valid !== 2'b00) seen = 1'b1;
      tick();
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL mid_no_rsp got seen=%b exp 0", seen); else pass_cnt++;
    req_valid = 2'b11;
    #1;
    chk_cnt++; if (req_ready !== 2'b01) $display("FAIL mid_ptr got %b exp 01", req_ready); else pass_cnt++;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_div0();
    int lat;
    issue(0, 8'd4, 8'd5, 4'd0, lat);
    chk_cnt++; if (lat != 2 || rsp_data !== 8'd9) $display("FAIL pre_div0 got lat %0d data %0d exp 2 9", lat, rsp_data); else pass_cnt++;
    finish_rsp(0);
    issue(1, 8'd9, 8'd0, 4'd3, lat);
`ifdef ALU_SCHED_DIV0_CHECK_EN
    chk_cnt++; if (lat != 1) $display("FAIL div0_lat got %0d exp 1", lat); else pass_cnt++;
    chk_cnt++; if ({rsp_data, rsp_carry, rsp_err} !== {8'h00, 1'b0, 1'b1}) $display("FAIL div0_rsp got %h/%b/%b exp 00/0/1", rsp_data, rsp_carry, rsp_err); else pass_cnt++;
    chk_cnt++; if ({alu_a, alu_sel} !== {8'd4, 4'd0}) $display("FAIL div0_alu got %0d %0d exp 4 0", alu_a, alu_sel); else pass_cnt++;
`else
    chk_cnt++; if (lat != 2) $display("FAIL div0_lat got %0d exp 2", lat); else pass_cnt++;
    chk_cnt++; if ({rsp_data, rsp_err} !== {8'hFF, 1'b0}) $display("FAIL div0_rsp got %h/%b exp ff/0", rsp_data, rsp_err); else pass_cnt++;
    chk_cnt++; if ({alu_a, alu_b, alu_sel} !== {8'd9, 8'd0, 4'd3}) $display("FAIL div0_alu got %0d %0d %0d exp 9 0 3", alu_a, alu_b, alu_sel); else pass_cnt++;
`endif
    finish_rsp(1);
  endtask

  task automatic test_back_to_back();
    int lat;
    int n;
    issue(0, 8'd7, 8'd8, 4'd0, lat);
    chk_cnt++; if (lat != 2 || rsp_data !== 8'd15) $display("FAIL b2b_first got lat %0d data %0d exp 2 15", lat, rsp_data); else pass_cnt++;
    req_a[7:0]   = 8'd33;
    req_b[7:0]   = 8'd2;
    req_sel[3:0] = 4'd2;
    req_valid    = 2'b01;
    rsp_ready    = 2'b01;
    #1;
    chk_cnt++; if (req_ready !== 2'b00) $display("FAIL b2b_same_cycle got %b exp 00", req_ready); else pass_cnt++;
    tick();
    rsp_ready = 2'b00;
    chk_cnt++; if (rsp_valid !== 2'b00 || req_ready !== 2'b01) $display("FAIL b2b_next got valid %b ready %b exp 00 01", rsp_valid, req_ready); else pass_cnt++;
    tick();
    req_valid = 2'b00;
    chk_cnt++; if (alu_a !== 8'd33 || alu_sel !== 4'd2) $display("FAIL b2b_alu got %0d %0d exp 33 2", alu_a, alu_sel); else pass_cnt++;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin tick(); n++; end
    chk_cnt++; if (n != 3 || rsp_data !== 8'd66) $display("FAIL b2b_rsp got lat %0d data %0d exp 3 66", n, rsp_data); else pass_cnt++;
    finish_rsp(0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_req1();
    test_round_robin();
    test_stall();
    test_reset_midop();
    test_div0();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter OP_LAT, default 1, meaning ALU result latency in clocks for every ALU_Sel other than 2.
REQ-002 SHALL have parameter MUL_LAT, default 2, meaning ALU result latency in clocks for ALU_Sel == 2 (multiply).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 2, operation request per requester i.
REQ-006 SHALL have port req_ready, output, 2, grant/accept per requester.
REQ-007 SHALL have port req_a, input, 16, operand A; requester i at [8i+7:8i].
REQ-008 SHALL have port req_b, input, 16, operand B; same packing as req_a.
REQ-009 SHALL have port req_sel, input, 8, ALU_Sel; requester i at [4i+3:4i].
REQ-010 SHALL have port rsp_valid, output, 2, result valid per requester, one-hot or zero.
REQ-011 SHALL have port rsp_ready, input, 2, result accept per requester.
REQ-012 SHALL have port rsp_data, output, 8, result byte, shared.
REQ-013 SHALL have port rsp_carry, output, 1, CarryOut captured with the result.
REQ-014 SHALL have port rsp_err, output, 1, divide-by-zero flag (see Configuration).
REQ-015 SHALL have ports alu_a (output, 8), alu_b (output, 8) and alu_sel (output, 4), which drive ALU A, B and ALU_Sel.
REQ-016 SHALL have ports alu_out (input, 8) and alu_carry (input, 1), which receive ALU ALU_Out and CarryOut.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-018 In IDLE with any req_valid, SHALL assert req_ready[g] combinationally for exactly one granted requester g.
REQ-019 SHALL complete the request handshake on the edge where req_valid[g] && req_ready[g]; req_ready SHALL be 0 outside IDLE.
REQ-020 On accept, SHALL capture a, b and sel of g into alu_a, alu_b and alu_sel, load the latency counter (MUL_LAT if sel == 2, else OP_LAT) and enter EXEC.
REQ-021 alu_a, alu_b and alu_sel SHALL hold stable from accept until the next accept.
REQ-022 In EXEC, SHALL stay LAT+1 cycles, then capture alu_out and alu_carry into rsp_data and rsp_carry and enter RESP.
  - With OP_LAT = 1, accept at edge E0 gives rsp_valid high after edge E0+2.
  - With MUL_LAT = 2, the same accept gives rsp_valid high after edge E0+3.
REQ-023 In RESP, SHALL hold rsp_valid[g] = 1 with rsp_data, rsp_carry and rsp_err stable until rsp_ready[g]; on that edge it SHALL return to IDLE.
REQ-024 rsp_ready of a non-granted requester SHALL be ignored.
REQ-025 Arbitration SHALL be round-robin: after a completed response from g, the other requester has priority.
REQ-026 When both req_valid are high in IDLE, the priority pointer SHALL decide the grant.
REQ-027 A single requester SHALL be granted regardless of the pointer.
REQ-028 Deasserting req_valid before the handshake SHALL cancel the request without side effect.
REQ-029 Back-to-back operation SHALL allow a new accept in the cycle following the rsp handshake, never in the same cycle.
REQ-030 At most one operation SHALL be outstanding, with no queuing.

Reset
REQ-031 On rst high at posedge clk, SHALL enter IDLE, give the priority pointer to requester 0, and set req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, alu_a, alu_b and alu_sel to 0.
REQ-032 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without producing a response.
REQ-033 rst SHALL dominate all other inputs.

Configuration
REQ-034 When macro ALU_SCHED_DIV0_CHECK_EN is defined, a request with sel == 3 and b == 0 SHALL be accepted and bypass EXEC.
  - The ALU ports are not updated.
  - One cycle later the block enters RESP with rsp_data = 8'h00, rsp_carry = 0 and rsp_err = 1.
REQ-035 When ALU_SCHED_DIV0_CHECK_EN is undefined, divide-by-zero SHALL be issued like any other operation and rsp_err SHALL be constant 0.

Verification
REQ-036 Reset, then requester 0 issues a=100, b=55, sel=0 -> rsp_valid[0] two edges after accept, rsp_data=155, rsp_carry=0, rsp_err=0.
REQ-037 Requester 1 issues a=200, b=100, sel=0 -> rsp_data=44, rsp_carry=1; then sel=2, a=12, b=10 -> rsp_data=120, rsp_valid three edges after accept.
REQ-038 Both requesters hold req_valid continuously for 4 ops -> grants alternate 0,1,0,1; there is never two rsp_valid bits set.
REQ-039 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable; no req_ready is asserted until the rsp handshake.
REQ-040 Assert rst in the EXEC cycle of a sel=3 op -> next cycle IDLE, all outputs 0, no rsp_valid, next grant to requester 0.
REQ-041 With ALU_SCHED_DIV0_CHECK_EN defined, a=9, b=0, sel=3 -> rsp_err=1, rsp_data=0, alu_sel unchanged; without the macro -> issued to ALU and rsp_err=0.
